// File: rtl/logic_func_unit_if.sv
// Bus bundle for logic_func_unit: evaluate, truth-table config and sweep control/status.
interface logic_func_unit_if #(
   parameter int unsigned N_IN = 4
);
   localparam int unsigned CNT_W = N_IN + 1;

   logic              in_valid;
   logic [N_IN-1:0]   in_vec;
   logic              out_valid;
   logic              out_f;
   logic              cfg_we;
   logic [N_IN-1:0]   cfg_addr;
   logic              cfg_data;
   logic              start;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  ones_cnt;
   logic              cfg_err;

   modport master (
      output in_valid, in_vec, cfg_we, cfg_addr, cfg_data, start,
      input  out_valid, out_f, busy, done, ones_cnt, cfg_err
   );

   modport slave (
      input  in_valid, in_vec, cfg_we, cfg_addr, cfg_data, start,
      output out_valid, out_f, busy, done, ones_cnt, cfg_err
   );
endinterface

// File: rtl/logic_func_unit.sv
// Programmable N_IN-input truth-table function with registered output and a minterm-count sweep.
// Optional build macro LFU_STICKY_ERR_EN: cfg_err holds after a rejected write until the next accepted start.
module logic_func_unit #(
   parameter int unsigned              N_IN    = 4,
   parameter logic [(1 << N_IN) - 1:0] TT_INIT = 16'hFFAF
) (
   input  logic             clk,
   input  logic             rst,
   logic_func_unit_if.slave bus
);
   localparam int unsigned TT_W  = 1 << N_IN;
   localparam int unsigned CNT_W = N_IN + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWEEP,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [TT_W-1:0]   table_q, table_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  ones_cnt_q, ones_cnt_d;
   logic              out_f_q, out_f_d;
   logic              out_valid_q, out_valid_d;
   logic              cfg_err_q, cfg_err_d;
   logic              busy;
   logic              done;
   logic              start_ok;
   logic              wr_reject;
   logic [CNT_W-1:0]  acc_sum;

   assign acc_sum = acc_q + CNT_W'(table_q[idx_q]);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      ones_cnt_d = ones_cnt_q;
      busy       = 1'b0;
      done       = 1'b0;
      start_ok   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            idx_d = '0;
            acc_d = '0;
            if (bus.start) begin
               state_d  = S_SWEEP;
               start_ok = 1'b1;
            end
         end
         S_SWEEP: begin
            busy  = 1'b1;
            acc_d = acc_sum;
            idx_d = idx_q + N_IN'(1);
            // Count is captured on the final sweep edge so it is already valid while done is high.
            if (idx_q == '1) begin
               state_d    = S_DONE;
               ones_cnt_d = acc_sum;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      table_d     = table_q;
      wr_reject   = bus.cfg_we & busy;
      out_valid_d = bus.in_valid;
      out_f_d     = out_f_q;
      if (bus.in_valid) begin
         out_f_d = table_q[bus.in_vec];
      end
      if (bus.cfg_we && !busy) begin
         table_d[bus.cfg_addr] = bus.cfg_data;
      end
`ifdef LFU_STICKY_ERR_EN
      cfg_err_d = wr_reject | (cfg_err_q & ~start_ok);
`else
      cfg_err_d = wr_reject;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         table_q     <= TT_INIT;
         idx_q       <= '0;
         acc_q       <= '0;
         ones_cnt_q  <= '0;
         out_f_q     <= 1'b0;
         out_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         table_q     <= table_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         ones_cnt_q  <= ones_cnt_d;
         out_f_q     <= out_f_d;
         out_valid_q <= out_valid_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_f     = out_f_q;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.ones_cnt  = ones_cnt_q;
   assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_logic_func_unit.sv
// Directed bench for logic_func_unit (N_IN=4, TT_INIT=16'hFFAF): vector table plus sweep sequences.
module tb_logic_func_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

`ifdef LFU_STICKY_ERR_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   always #5 clk = ~clk;

   logic_func_unit_if #(.N_IN(4)) bus ();

   logic_func_unit #(
      .N_IN    (4),
      .TT_INIT (16'hFFAF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       in_valid;
      logic [3:0] in_vec;
      logic       cfg_we;
      logic [3:0] cfg_addr;
      logic       cfg_data;
      logic       exp_valid;
      logic       exp_f;
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic idle_inputs();
      bus.in_valid = 1'b0;
      bus.in_vec   = '0;
      bus.cfg_we   = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_data = 1'b0;
      bus.start    = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic eval(input logic [3:0] v, input logic exp, input string name);
      bus.in_valid = 1'b1;
      bus.in_vec   = v;
      tick();
      bus.in_valid = 1'b0;
      check(name, bus.out_f, exp);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   initial begin
      int busy_n;
      int dones;
      logic [4:0] cnt_at_done;

      idle_inputs();
      tick();

      // reset state
      rst = 1'b1;
      tick();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_f", bus.out_f, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_ones_cnt", bus.ones_cnt, 0);
      check("rst_cfg_err", bus.cfg_err, 0);
      tick();
      rst = 1'b0;

      // {in_valid, in_vec, cfg_we, cfg_addr, cfg_data, exp_valid, exp_f}
      vecs.push_back('{1'b1, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd1,  1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd2,  1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd3,  1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd4,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 4'd5,  1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd6,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 4'd7,  1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd8,  1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd9,  1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd10, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd11, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd12, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd13, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd14, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 4'd4,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 4'd4,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 4'd6,  1'b1, 4'd6, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 4'd6,  1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 4'd0,  1'b1, 4'd4, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 4'd4,  1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd15, 1'b1, 4'd15, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0});

      foreach (vecs[i]) begin
         bus.in_valid = vecs[i].in_valid;
         bus.in_vec   = vecs[i].in_vec;
         bus.cfg_we   = vecs[i].cfg_we;
         bus.cfg_addr = vecs[i].cfg_addr;
         bus.cfg_data = vecs[i].cfg_data;
         tick();
         check($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].exp_valid);
         check($sformatf("vec%0d_f", i), bus.out_f, vecs[i].exp_f);
      end
      idle_inputs();

      // sweep of the reset table
      do_reset();
      pulse_start();
      busy_n = 0;
      dones = 0;
      cnt_at_done = '0;
      for (int c = 1; c <= 24; c++) begin
         if (bus.busy) busy_n++;
         if (bus.done) begin
            dones++;
            cnt_at_done = bus.ones_cnt;
            check("t3_done_cycle", c, 17);
            check("t3_busy_at_done", bus.busy, 0);
         end
         tick();
      end
      check("t3_busy_cycles", busy_n, 16);
      check("t3_done_count", dones, 1);
      check("t3_cnt_at_done", cnt_at_done, 5'd14);
      check("t3_ones_cnt", bus.ones_cnt, 5'd14);

      // rejected write and ignored restart during a sweep
      do_reset();
      pulse_start();
      busy_n = 0;
      dones = 0;
      cnt_at_done = '0;
      for (int c = 1; c <= 24; c++) begin
         if (bus.busy) busy_n++;
         if (bus.done) begin
            dones++;
            cnt_at_done = bus.ones_cnt;
         end
         bus.cfg_we   = (c == 3);
         bus.cfg_addr = 4'd0;
         bus.cfg_data = 1'b0;
         bus.start    = (c == 6);
         tick();
         if (c == 2) check("t4_err_before", bus.cfg_err, 0);
         if (c == 3) check("t4_err_pulse", bus.cfg_err, 1);
         if (c == 4) check("t4_err_after", bus.cfg_err, STICKY);
      end
      idle_inputs();
      check("t4_busy_cycles", busy_n, 16);
      check("t4_done_count", dones, 1);
      check("t4_ones_cnt", cnt_at_done, 5'd14);
      check("t4_err_end", bus.cfg_err, STICKY);
      eval(4'd0, 1'b1, "t4_table_bit0");
      check("t4_err_after_eval", bus.cfg_err, STICKY);
      pulse_start();
      check("t4_err_cleared", bus.cfg_err, 0);
      check("t4_restart_busy", bus.busy, 1);
      for (int c = 0; c < 20; c++) tick();
      check("t4_idle_after", bus.busy, 0);

      // reset in the middle of a sweep after a table edit
      do_reset();
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 4'd6;
      bus.cfg_data = 1'b1;
      tick();
      idle_inputs();
      eval(4'd6, 1'b1, "t5_edit_visible");
      pulse_start();
      dones = 0;
      for (int c = 1; c <= 30; c++) begin
         rst = (c == 8);
         tick();
         if (c == 8) check("t5_busy_after_rst", bus.busy, 0);
         if (bus.done) dones++;
      end
      rst = 1'b0;
      check("t5_done_count", dones, 0);
      check("t5_ones_cnt", bus.ones_cnt, 0);
      check("t5_cfg_err", bus.cfg_err, 0);
      eval(4'd6, 1'b0, "t5_table_bit6");
      eval(4'd4, 1'b0, "t5_table_bit4");
      eval(4'd5, 1'b1, "t5_table_bit5");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
